burst_slave_read: RTL and testbench

//  Avalon-MM burst read slave: accepts one burst read command, streams burstcount consecutive words from an

---
 rtl/burst_slave_pkg.sv | 20 ++
 rtl/burst_slave_rd_mem.sv | 38 +++
 rtl/burst_slave_read.sv | 139 +++++++++++++
 tb/tb_burst_slave_read.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/burst_slave_pkg.sv
// rtl/burst_slave_pkg.sv - shared types and helpers for the burst read slave
//   state_t      : FSM states IDLE, BURST, DRAIN
//   IDXW         : memory index width for the default depth
//   lane_byte()  : returns a byte or zero depending on its byte-enable bit
package burst_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH = 16;
    localparam int IDXW          = $clog2(DEFAULT_DEPTH);

    function automatic logic [7:0] lane_byte(input logic en, input logic [7:0] b);
        return en ? b : 8'h00;
    endfunction

endpackage

// File: rtl/burst_slave_rd_mem.sv
// rtl/burst_slave_rd_mem.sv - DEPTH x DW memory, sync read-first port, load port, sync clear
//   clk_i, rst_i        : clock, synchronous active-high clear of array and read register
//   rd_en, rd_idx       : registered read; rd_data updates the edge after rd_en is sampled
//   ld_we, ld_addr, ld_data : full-word write port
module burst_slave_rd_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DW-1:0]            rd_data,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DW-1:0]            ld_data
);

    logic [DW-1:0] mem [DEPTH];

    // Read and write in the same edge: the nonblocking read samples the old word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (rd_en) begin
                rd_data <= mem[rd_idx];
            end
            if (ld_we) begin
                mem[ld_addr] <= ld_data;
            end
        end
    end

endmodule

// File: rtl/burst_slave_read.sv
// rtl/burst_slave_read.sv - Avalon-MM burst read slave over a local preloadable memory
//   Option macro: BURST_SLAVE_RD_OUTREG_EN adds one output register stage (one cycle more latency).
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   avms_address/burstcount/read/byteenable : burst command (accepted when waitrequest low)
//   avms_readdata, avms_readdatavalid        : one beat per cycle, data zero when not valid
//   avms_waitrequest                          : high whenever the FSM is not IDLE
//   ld_we, ld_addr, ld_data                   : local memory load port
import burst_slave_pkg::*;

module burst_slave_read #(
    parameter int DW              = 32,
    parameter int AW              = 16,
    parameter int BURSTCOUNTWIDTH = 4,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int DEPTH           = DEFAULT_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [AW-1:0]              avms_address,
    input  logic [BURSTCOUNTWIDTH-1:0] avms_burstcount,
    input  logic                       avms_read,
    input  logic [BYTEENABLEWIDTH-1:0] avms_byteenable,
    output logic [DW-1:0]              avms_readdata,
    output logic                       avms_readdatavalid,
    output logic                       avms_waitrequest,
    input  logic                       ld_we,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [DW-1:0]              ld_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = BURSTCOUNTWIDTH + 1;

`ifdef BURST_SLAVE_RD_OUTREG_EN
    localparam logic DRAIN_EXTRA = 1'b1;
`else
    localparam logic DRAIN_EXTRA = 1'b0;
`endif

    state_t                     state_q;
    logic [IW-1:0]              addr_q;
    logic [CW-1:0]              beats_left_q;
    logic [BYTEENABLEWIDTH-1:0] be_q;
    logic                       drain_q;
    logic                       v1_q;
    logic [DW-1:0]              rd_data;
    logic [DW-1:0]              masked;
    logic [CW-1:0]              n_beats;
    logic                       rd_en;

    // Upper address bits do not select memory; the index wraps modulo DEPTH.
    logic addr_hi_unused;
    assign addr_hi_unused = ^avms_address[AW-1:IW];

    assign n_beats = (avms_burstcount == '0) ? CW'(1) : CW'(avms_burstcount);
    assign rd_en   = (state_q == BURST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            be_q         <= '0;
            drain_q      <= 1'b0;
            v1_q         <= 1'b0;
        end else begin
            v1_q <= rd_en;
            case (state_q)
                IDLE: begin
                    if (avms_read) begin
                        addr_q       <= avms_address[IW-1:0];
                        be_q         <= avms_byteenable;
                        beats_left_q <= n_beats;
                        state_q      <= BURST;
                    end
                end
                BURST: begin
                    addr_q       <= addr_q + 1'b1;
                    beats_left_q <= beats_left_q - 1'b1;
                    if (beats_left_q == CW'(1)) begin
                        state_q <= DRAIN;
                        drain_q <= DRAIN_EXTRA;
                    end
                end
                DRAIN: begin
                    // Hold off new commands until the last beat has left the output.
                    if (drain_q) begin
                        drain_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign avms_waitrequest = (state_q != IDLE);

    burst_slave_rd_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rd_en   (rd_en),
        .rd_idx  (addr_q),
        .rd_data (rd_data),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    for (genvar i = 0; i < BYTEENABLEWIDTH; i++) begin : g_lane
        assign masked[8*i +: 8] = lane_byte(be_q[i], rd_data[8*i +: 8]);
    end

`ifdef BURST_SLAVE_RD_OUTREG_EN
    logic [DW-1:0] rdata_q;
    logic          v2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            v2_q    <= 1'b0;
        end else begin
            rdata_q <= v1_q ? masked : '0;
            v2_q    <= v1_q;
        end
    end

    assign avms_readdata      = rdata_q;
    assign avms_readdatavalid = v2_q;
`else
    assign avms_readdata      = v1_q ? masked : '0;
    assign avms_readdatavalid = v1_q;
`endif

endmodule

// File: tb/tb_burst_slave_read.sv
// tb/tb_burst_slave_read.sv - table-driven bench for burst_slave_read
module tb_burst_slave_read;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] avms_address;
    logic [3:0]  avms_burstcount;
    logic        avms_read;
    logic [3:0]  avms_byteenable;
    logic [31:0] avms_readdata;
    logic        avms_readdatavalid;
    logic        avms_waitrequest;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;

    burst_slave_read dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .avms_address       (avms_address),
        .avms_burstcount    (avms_burstcount),
        .avms_read          (avms_read),
        .avms_byteenable    (avms_byteenable),
        .avms_readdata      (avms_readdata),
        .avms_readdatavalid (avms_readdatavalid),
        .avms_waitrequest   (avms_waitrequest),
        .ld_we              (ld_we),
        .ld_addr            (ld_addr),
        .ld_data            (ld_data)
    );

    always #5 clk_i = ~clk_i;

    // One row per clock: inputs driven before the edge that closes the row,
    // expectations for outputs visible during the row (result of earlier edges).
    typedef struct {
        logic        rst;
        logic        rd;
        logic [15:0] addr;
        logic [3:0]  cnt;
        logic [3:0]  be;
        logic        ldwe;
        logic [3:0]  lda;
        logic [31:0] ldd;
        logic        chk;
        logic        ev;
        logic [31:0] ed;
        logic        ew;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic row(input logic rst, input logic rd, input logic [15:0] addr,
                       input logic [3:0] cnt, input logic [3:0] be, input logic ldwe,
                       input logic [3:0] lda, input logic [31:0] ldd, input logic chk,
                       input logic ev, input logic [31:0] ed, input logic ew);
        vec_t v;
        v.rst = rst; v.rd = rd; v.addr = addr; v.cnt = cnt; v.be = be;
        v.ldwe = ldwe; v.lda = lda; v.ldd = ldd; v.chk = chk;
        v.ev = ev; v.ed = ed; v.ew = ew;
        vq.push_back(v);
    endtask

    task automatic nop(input logic ev, input logic [31:0] ed, input logic ew);
        row(1'b0, 1'b0, 16'd0, 4'd0, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1, ev, ed, ew);
    endtask

    task automatic ld(input logic [3:0] a, input logic [31:0] d,
                      input logic ev, input logic [31:0] ed, input logic ew);
        row(1'b0, 1'b0, 16'd0, 4'd0, 4'hF, 1'b1, a, d, 1'b1, ev, ed, ew);
    endtask

    task automatic rd(input logic [15:0] a, input logic [3:0] c, input logic [3:0] be,
                      input logic ev, input logic [31:0] ed, input logic ew);
        row(1'b0, 1'b1, a, c, be, 1'b0, 4'd0, 32'd0, 1'b1, ev, ed, ew);
    endtask

    task automatic check(input int r, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row%0d %s: got %h expected %h", r, name, act, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; avms_address = '0; avms_burstcount = '0; avms_read = 1'b0;
        avms_byteenable = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;

        row(1'b1, 1'b0, 16'd0, 4'd0, 4'hF, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
`ifdef BURST_SLAVE_RD_OUTREG_EN
        ld(4'd0, 32'h1111_1111, 0, 0, 0);
        ld(4'd1, 32'h2222_2222, 0, 0, 0);
        ld(4'd2, 32'h3333_3333, 0, 0, 0);
        ld(4'd3, 32'h4444_4444, 0, 0, 0);
        rd(16'd0, 4'd4, 4'hF, 0, 0, 0);                // T=5
        nop(0, 0, 1);
        nop(0, 0, 1);
        nop(1, 32'h1111_1111, 1);                       // T+3
        nop(1, 32'h2222_2222, 1);
        nop(1, 32'h3333_3333, 1);
        nop(1, 32'h4444_4444, 1);                       // T+6
        rd(16'd0, 4'd2, 4'hF, 0, 0, 0);                // T=12, waitrequest low at T+7
        nop(0, 0, 1);
        ld(4'd1, 32'h9999_9999, 0, 0, 1);              // load idx1 on the edge that reads it
        nop(1, 32'h1111_1111, 1);
        nop(1, 32'h2222_2222, 1);                       // old word returned
        rd(16'd1, 4'd1, 4'hF, 0, 0, 0);
        nop(0, 0, 1);
        nop(0, 0, 1);
        nop(1, 32'h9999_9999, 1);
        nop(0, 0, 0);
`else
        ld(4'd0, 32'h1111_1111, 0, 0, 0);
        ld(4'd1, 32'h2222_2222, 0, 0, 0);
        ld(4'd2, 32'h3333_3333, 0, 0, 0);
        ld(4'd3, 32'h4444_4444, 0, 0, 0);
        rd(16'd0, 4'd4, 4'hF, 0, 0, 0);                // T=5
        nop(0, 0, 1);
        nop(1, 32'h1111_1111, 1);
        nop(1, 32'h2222_2222, 1);
        nop(1, 32'h3333_3333, 1);
        nop(1, 32'h4444_4444, 1);
        rd(16'd2, 4'd1, 4'b0011, 0, 0, 0);             // T+6: idle again, new command
        nop(0, 0, 1);
        nop(1, 32'h0000_3333, 1);
        ld(4'd14, 32'hE, 0, 0, 0);
        ld(4'd15, 32'hF, 0, 0, 0);
        ld(4'd0, 32'hA, 0, 0, 0);
        ld(4'd1, 32'hB, 0, 0, 0);
        rd(16'd14, 4'd4, 4'hF, 0, 0, 0);               // wraps 14,15,0,1
        nop(0, 0, 1);
        nop(1, 32'hE, 1);
        nop(1, 32'hF, 1);
        nop(1, 32'hA, 1);
        nop(1, 32'hB, 1);
        rd(16'd0, 4'd4, 4'hF, 0, 0, 0);                // T=24, read held high below
        rd(16'd8, 4'd1, 4'hF, 0, 0, 1);
        rd(16'd8, 4'd1, 4'hF, 1, 32'hA, 1);
        rd(16'd8, 4'd1, 4'hF, 1, 32'hB, 1);
        rd(16'd8, 4'd1, 4'hF, 1, 32'h3333_3333, 1);
        rd(16'd8, 4'd1, 4'hF, 1, 32'h4444_4444, 1);
        rd(16'd2, 4'd2, 4'hF, 0, 0, 0);                // accepted at T+6
        nop(0, 0, 1);
        nop(1, 32'h3333_3333, 1);                       // first valid T+8
        nop(1, 32'h4444_4444, 1);
        rd(16'd0, 4'd4, 4'hF, 0, 0, 0);                // T=34
        nop(0, 0, 1);
        nop(1, 32'hA, 1);
        row(1'b1, 1'b0, 16'd0, 4'd0, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 32'hB, 1'b1);
        nop(0, 0, 0);                                   // reset aborted the burst
        ld(4'd5, 32'hDEAD_BEEF, 0, 0, 0);
        rd(16'd5, 4'd0, 4'hF, 0, 0, 0);                // burstcount 0 -> one beat
        nop(0, 0, 1);
        nop(1, 32'hDEAD_BEEF, 1);
        nop(0, 0, 0);
        rd(16'd0, 4'd1, 4'hF, 0, 0, 0);                // memory cleared by reset
        nop(0, 0, 1);
        nop(1, 32'h0, 1);
        rd(16'd6, 4'd1, 4'hF, 0, 0, 0);
        ld(4'd6, 32'h1234_5678, 0, 0, 1);              // same-edge load and read
        nop(1, 32'h0, 1);
        rd(16'd6, 4'd1, 4'hF, 0, 0, 0);
        nop(0, 0, 1);
        nop(1, 32'h1234_5678, 1);
        nop(0, 0, 0);
`endif

        for (int r = 0; r < vq.size(); r++) begin
            @(negedge clk_i);
            if (vq[r].chk) begin
                check(r, "valid", {31'd0, avms_readdatavalid}, {31'd0, vq[r].ev});
                check(r, "data",  avms_readdata, vq[r].ed);
                check(r, "waitrequest", {31'd0, avms_waitrequest}, {31'd0, vq[r].ew});
            end
            rst_i           = vq[r].rst;
            avms_read       = vq[r].rd;
            avms_address    = vq[r].addr;
            avms_burstcount = vq[r].cnt;
            avms_byteenable = vq[r].be;
            ld_we           = vq[r].ldwe;
            ld_addr         = vq[r].lda;
            ld_data         = vq[r].ldd;
        end
        @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
